// File: rtl/fixed_point_product_accumulator_if.sv
// Bundle between the multiplier array, the product accumulator and the writeback stage.
// The master drives jobs and products and accepts results; the slave is the accumulator.
interface fixed_point_product_accumulator_if #(
    parameter int NUM_INSTANCES = 32,
    parameter int WIDTH         = 14,
    parameter int LEN_W         = 8
);
    logic                           start;
    logic [LEN_W-1:0]               acc_len;
    logic                           data_valid;
    logic [NUM_INSTANCES*WIDTH-1:0] Mul_result;
    logic [WIDTH-1:0]               acc_result;
    logic                           acc_valid;
    logic                           acc_ready;
    logic                           sat;
    logic                           busy;
    logic                           overrun;

    modport master (
        output start, acc_len, data_valid, Mul_result, acc_ready,
        input  acc_result, acc_valid, sat, busy, overrun
    );

    modport slave (
        input  start, acc_len, data_valid, Mul_result, acc_ready,
        output acc_result, acc_valid, sat, busy, overrun
    );
endinterface

// File: rtl/fixed_point_product_accumulator.sv
// Sums all lanes of each product beat, accumulates a job of acc_len beats at full
// precision, and presents one saturated result per job on a valid/ready output.
module fixed_point_product_accumulator #(
    parameter int NUM_INSTANCES = 32,
    parameter int WIDTH         = 14,
    parameter int FRAC_BITS     = 7,
    parameter int LEN_W         = 8
) (
    input logic                              clk,
    input logic                              rst,
    fixed_point_product_accumulator_if.slave bus
);
    localparam int SUM_W = WIDTH + $clog2(NUM_INSTANCES);
    localparam int ACC_W = SUM_W + LEN_W;

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (WIDTH-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(1 << (WIDTH-1)));

    // The binary point never moves through this block, so FRAC_BITS only has to be sane.
    generate
        if (FRAC_BITS < 0 || FRAC_BITS >= WIDTH) begin : g_frac_bits_out_of_range
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_LAST
    } state_t;

    state_t state_reg, state_next;

    logic [LEN_W-1:0]        len_reg;
    logic [LEN_W-1:0]        beat_cnt_reg;
    logic signed [SUM_W-1:0] sum_r_reg;
    logic                    sum_v_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic [WIDTH-1:0]        acc_result_reg;
    logic                    acc_valid_reg;
    logic                    sat_reg;
    logic                    overrun_reg;

    logic                    job_start;
    logic                    beat_accept;
    logic                    job_done;

    logic signed [SUM_W-1:0] lane_ext [NUM_INSTANCES];
    logic signed [SUM_W-1:0] lane_sum;
    logic signed [ACC_W:0]   final_sum;
    logic [WIDTH-1:0]        sat_value;
    logic                    sat_flag;

    // Sign-extend every lane to the full lane-sum width before adding.
    generate
        for (genvar gi = 0; gi < NUM_INSTANCES; gi++) begin : g_lane
            assign lane_ext[gi] = SUM_W'($signed(bus.Mul_result[gi*WIDTH +: WIDTH]));
        end
    endgenerate

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < NUM_INSTANCES; i++) begin
            lane_sum = lane_sum + lane_ext[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        job_start   = 1'b0;
        beat_accept = 1'b0;
        job_done    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    job_start  = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.data_valid) begin
                    beat_accept = 1'b1;
                    if (beat_cnt_reg + LEN_W'(1) == len_reg) begin
                        state_next = ST_LAST;
                    end
                end
            end
            ST_LAST: begin
                // The final beat's lane sum sits in sum_r during this cycle.
                job_done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign final_sum = (ACC_W+1)'(acc_reg) + (ACC_W+1)'(sum_r_reg);

    always_comb begin
        sat_value = final_sum[WIDTH-1:0];
        sat_flag  = 1'b0;
        if (final_sum > SAT_MAX) begin
            sat_value = SAT_MAX[WIDTH-1:0];
            sat_flag  = 1'b1;
        end else if (final_sum < SAT_MIN) begin
            sat_value = SAT_MIN[WIDTH-1:0];
            sat_flag  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_reg      <= '0;
            beat_cnt_reg <= '0;
            sum_r_reg    <= '0;
            sum_v_reg    <= 1'b0;
            acc_reg      <= '0;
        end else begin
            sum_v_reg <= beat_accept;
            if (beat_accept) begin
                sum_r_reg    <= lane_sum;
                beat_cnt_reg <= beat_cnt_reg + LEN_W'(1);
            end
            if (job_start) begin
                len_reg      <= (bus.acc_len == '0) ? LEN_W'(1) : bus.acc_len;
                beat_cnt_reg <= '0;
                acc_reg      <= '0;
            end else if (job_done) begin
                acc_reg <= '0;
            end else if (sum_v_reg) begin
                acc_reg <= acc_reg + ACC_W'(sum_r_reg);
            end
        end
    end

    // A finishing job only overwrites the output when the old result leaves this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_result_reg <= '0;
            acc_valid_reg  <= 1'b0;
            sat_reg        <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            if (job_start) begin
                overrun_reg <= 1'b0;
            end
            if (job_done) begin
                if (acc_valid_reg && !bus.acc_ready) begin
                    overrun_reg <= 1'b1;
                end else begin
                    acc_result_reg <= sat_value;
                    sat_reg        <= sat_flag;
                    acc_valid_reg  <= 1'b1;
                end
            end else if (acc_valid_reg && bus.acc_ready) begin
                acc_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.acc_result = acc_result_reg;
    assign bus.acc_valid  = acc_valid_reg;
    assign bus.sat        = sat_reg;
    assign bus.overrun    = overrun_reg;
    assign bus.busy       = (state_reg == ST_RUN) || (state_reg == ST_LAST);

endmodule

// File: tb/tb_fixed_point_product_accumulator.sv
// Bench for the product accumulator: directed jobs with literal expectations, then a
// long randomized run checked every cycle against a job-level reference model.
module tb_fixed_point_product_accumulator;
    localparam int NI = 32;
    localparam int W  = 14;
    localparam int LW = 8;
    localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (W-1));

    logic clk = 1'b0;
    logic rst = 1'b0;

    fixed_point_product_accumulator_if #(.NUM_INSTANCES(NI), .WIDTH(W), .LEN_W(LW)) bus ();

    fixed_point_product_accumulator #(
        .NUM_INSTANCES(NI), .WIDTH(W), .FRAC_BITS(7), .LEN_W(LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks_total++;
        if (act == exp) checks_passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- job-level reference model ----------------
    bit     m_active  = 0;   // job started, not all beats seen
    bit     m_closing = 0;   // all beats seen; result is produced on the next edge
    int     m_len     = 0;
    int     m_cnt     = 0;
    longint m_total   = 0;
    bit     m_valid   = 0;
    longint m_result  = 0;
    bit     m_sat     = 0;
    bit     m_overrun = 0;
    int     xfer_count = 0;

    function automatic longint beat_sum(input logic [NI*W-1:0] v);
        longint s = 0;
        for (int i = 0; i < NI; i++) begin
            logic signed [W-1:0] lane;
            lane = v[i*W +: W];
            s += longint'(lane);
        end
        return s;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 0; m_closing = 0; m_len = 0; m_cnt = 0; m_total = 0;
            m_valid = 0; m_result = 0; m_sat = 0; m_overrun = 0;
        end else begin
            bit xfer;
            xfer = m_valid && bus.acc_ready;
            if (xfer) begin
                xfer_count++;
                $display("xfer %0d: result=%0d sat=%0d t=%0t", xfer_count, m_result, m_sat, $time);
            end
            if (m_closing) begin
                m_closing = 0;
                if (m_valid && !bus.acc_ready) begin
                    m_overrun = 1;
                end else begin
                    m_valid = 1;
                    m_sat   = (m_total > MAXV) || (m_total < MINV);
                    m_result = (m_total > MAXV) ? MAXV : (m_total < MINV) ? MINV : m_total;
                end
            end else begin
                if (xfer) m_valid = 0;
                if (!m_active) begin
                    if (bus.start) begin
                        m_active  = 1;
                        m_len     = (bus.acc_len == 0) ? 1 : int'(bus.acc_len);
                        m_cnt     = 0;
                        m_total   = 0;
                        m_overrun = 0;
                    end
                end else if (bus.data_valid) begin
                    m_total += beat_sum(bus.Mul_result);
                    m_cnt++;
                    if (m_cnt == m_len) begin
                        m_active  = 0;
                        m_closing = 1;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("acc_valid", bus.acc_valid, m_valid);
        check("busy", bus.busy, m_active || m_closing);
        check("overrun", bus.overrun, m_overrun);
        if (m_valid) begin
            check("acc_result", longint'($signed(bus.acc_result)), m_result);
            check("sat", bus.sat, m_sat);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input int v, input bit lane0_only);
        for (int i = 0; i < NI; i++)
            bus.Mul_result[i*W +: W] = (lane0_only && i != 0) ? '0 : W'(v);
    endtask

    task automatic start_job(input int len);
        bus.start   = 1'b1;
        bus.acc_len = LW'(len);
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic beat(input int v);
        set_lanes(v, 1'b0);
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.acc_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_arrived"}, bus.acc_valid, 1);
    endtask

    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        int seen;
        longint seen_result;
        int xc0;

        bus.start = 0; bus.acc_len = '0; bus.data_valid = 0;
        bus.Mul_result = '0; bus.acc_ready = 1;
        tick(); tick();
        check("reset_acc_valid", bus.acc_valid, 0);
        check("reset_acc_result", bus.acc_result, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_overrun", bus.overrun, 0);
        rst = 1'b1;
        tick();

        // 1: single beat of 1.0 in every lane -> 32.0
        start_job(1);
        set_lanes(128, 1'b0);
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        check("t1_valid_one_edge", bus.acc_valid, 0);
        tick();
        check("t1_valid_two_edges", bus.acc_valid, 1);
        check("t1_result", longint'($signed(bus.acc_result)), 4096);
        check("t1_sat", bus.sat, 0);
        tick(); tick();

        // 2: positive clip
        start_job(2); beat(128); beat(128);
        wait_valid("t2");
        check("t2_result", longint'($signed(bus.acc_result)), 8191);
        check("t2_sat", bus.sat, 1);
        tick(); tick();

        // 3: exact negative limit, then negative clip
        start_job(2); beat(-128); beat(-128);
        wait_valid("t3a");
        check("t3a_result_raw", bus.acc_result, 'h2000);
        check("t3a_sat", bus.sat, 0);
        tick(); tick();
        start_job(3); beat(-128); beat(-128); beat(-128);
        wait_valid("t3b");
        check("t3b_result", longint'($signed(bus.acc_result)), -8192);
        check("t3b_sat", bus.sat, 1);
        tick(); tick();

        // 4: gapped beats, lane0 = 0.5
        start_job(4);
        set_lanes(64, 1'b1);
        for (int k = 0; k < 7; k++) begin
            bus.data_valid = pat[k];
            tick();
            check("t4_busy", bus.busy, 1);
        end
        bus.data_valid = 1'b0;
        seen = 0; seen_result = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.acc_valid) begin
                seen++;
                seen_result = longint'($signed(bus.acc_result));
            end
            tick();
        end
        check("t4_valid_cycles", seen, 1);
        check("t4_result", seen_result, 256);

        // 5a: back-to-back jobs, output blocked -> second result dropped
        bus.acc_ready = 1'b0;
        start_job(1); beat(128); tick();
        start_job(1); beat(64); tick();
        check("t5a_valid", bus.acc_valid, 1);
        check("t5a_result_kept", longint'($signed(bus.acc_result)), 4096);
        check("t5a_overrun", bus.overrun, 1);
        bus.acc_ready = 1'b1;
        tick();
        check("t5a_drained", bus.acc_valid, 0);
        check("t5a_overrun_sticky", bus.overrun, 1);

        // 5b: old result leaves in the same cycle the new one lands
        bus.acc_ready = 1'b0;
        start_job(1); beat(128); tick();
        xc0 = xfer_count;
        start_job(1); beat(64);
        bus.acc_ready = 1'b1;
        tick();
        check("t5b_valid", bus.acc_valid, 1);
        check("t5b_result_new", longint'($signed(bus.acc_result)), 2048);
        check("t5b_overrun", bus.overrun, 0);
        tick();
        check("t5b_both_delivered", xfer_count - xc0, 2);
        tick();

        // 6: reset in the middle of a job
        start_job(3); beat(128); beat(128);
        rst = 1'b0;
        #1;
        check("t6_valid", bus.acc_valid, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_result", bus.acc_result, 0);
        check("t6_sat", bus.sat, 0);
        check("t6_overrun", bus.overrun, 0);
        tick();
        rst = 1'b1;
        tick();
        start_job(1); beat(1);
        wait_valid("t6_after");
        check("t6_after_result", longint'($signed(bus.acc_result)), 32);
        tick(); tick();

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            bit full;
            bus.start      = ($urandom_range(0, 99) < 25);
            bus.acc_len    = LW'($urandom_range(0, 5));
            bus.data_valid = ($urandom_range(0, 99) < 70);
            bus.acc_ready  = ($urandom_range(0, 99) < 70);
            full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NI; i++) begin
                int v;
                v = full ? int'($urandom_range(0, 16383)) - 8192
                         : int'($urandom_range(0, 600)) - 300;
                bus.Mul_result[i*W +: W] = W'(v);
            end
            if (c % 997 == 500) rst = 1'b0;
            tick();
            rst = 1'b1;
        end

        bus.start = 0; bus.data_valid = 0; bus.acc_ready = 1;
        for (int k = 0; k < 20; k++) tick();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
